// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex scan controller for common-anode seven-segment digits.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module hex_display_scanner #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 50000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    output logic [3:0]                digit_nibble,
    output logic [NUM_DIGITS-1:0]     digit_en_n,
    output logic [2:0]                digit_idx,
    output logic                      frame_start,
    output logic                      update_pending
);

    localparam int unsigned     CntW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(PRESCALE - 1);
    localparam logic [2:0]      IdxLast = 3'(NUM_DIGITS - 1);

    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   disp_q, disp_d;
    logic [4*NUM_DIGITS-1:0]   pend_q, pend_d;
    logic                      pend_valid_q, pend_valid_d;
    logic                      tick, wrap;
    logic [3:0]                nibble_d;
    logic [NUM_DIGITS-1:0]     en_n_d;
    logic [NUM_DIGITS-1:0]     blank;
`ifdef LEADING_ZERO_BLANK_EN
    logic                      upper_zero;
`endif

    always_comb begin
        tick  = (cnt_q == '0);
        wrap  = tick && (idx_q == IdxLast);
        cnt_d = tick ? CntMax : cnt_q - 1'b1;
        idx_d = wrap ? 3'd0 : (tick ? idx_q + 3'd1 : idx_q);

        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        // A load landing on the wrap edge goes straight to the display.
        if (wrap) begin
            if (load) begin
                disp_d = data_in;
            end else if (pend_valid_q) begin
                disp_d = pend_q;
            end
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_d       = data_in;
            pend_valid_d = 1'b1;
        end

        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (disp_d[4*i +: 4] == 4'h0);
            blank[i]   = upper_zero;
        end
`endif

        nibble_d = 4'h0;
        en_n_d   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == 3'(i)) begin
                nibble_d  = disp_d[4*i +: 4];
                en_n_d[i] = blank[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= CntMax;
            idx_q        <= 3'd0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            digit_nibble <= 4'h0;
            digit_en_n   <= '1;
            frame_start  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            digit_nibble <= nibble_d;
            digit_en_n   <= en_n_d;
            frame_start  <= wrap;
        end
    end

    assign digit_idx      = idx_q;
    assign update_pending = pend_valid_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner; reference model derives the scan
// position from the edge count since reset release and tracks staged loads.
module tb_hex_display_scanner;

    localparam int N  = 4;
    localparam int P  = 4;
    localparam int NP = N * P;

    logic           clk;
    logic           rst_n;
    logic           load;
    logic [4*N-1:0] data_in;
    logic [3:0]     digit_nibble;
    logic [N-1:0]   digit_en_n;
    logic [2:0]     digit_idx;
    logic           frame_start;
    logic           update_pending;

    int checks = 0;
    int errors = 0;

    // Reference model state: edges since reset release and value bookkeeping.
    int             n;
    logic [4*N-1:0] m_disp;
    logic [4*N-1:0] m_pend;
    bit             m_pv;

    hex_display_scanner #(
        .NUM_DIGITS(N),
        .PRESCALE  (P)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load),
        .data_in       (data_in),
        .digit_nibble  (digit_nibble),
        .digit_en_n    (digit_en_n),
        .digit_idx     (digit_idx),
        .frame_start   (frame_start),
        .update_pending(update_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_nibble"}, 32'(digit_nibble), 32'h0);
        check({tag, "_en_n"}, 32'(digit_en_n), 32'hF);
        check({tag, "_idx"}, 32'(digit_idx), 32'h0);
        check({tag, "_fs"}, 32'(frame_start), 32'h0);
        check({tag, "_upd"}, 32'(update_pending), 32'h0);
    endtask

    task automatic model_reset();
        n      = 0;
        m_disp = '0;
        m_pend = '0;
        m_pv   = 1'b0;
    endtask

    task automatic model_edge(input bit l, input logic [4*N-1:0] d);
        bit w;
        n++;
        w = (n % NP) == 0;
        if (w) begin
            if (l) m_disp = d;
            else if (m_pv) m_disp = m_pend;
            m_pv = 1'b0;
        end else if (l) begin
            m_pend = d;
            m_pv   = 1'b1;
        end
    endtask

    task automatic check_outputs();
        int           idx;
        logic [3:0]   exp_nib;
        logic [N-1:0] exp_en;
        bit           blanked;
        idx     = (n / P) % N;
        exp_nib = 4'((m_disp >> (4 * idx)) & 'hF);
        blanked = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blanked = (idx >= 1) && ((m_disp >> (4 * idx)) == 0);
`endif
        exp_en = blanked ? '1 : ~(N'(1) << idx);
        check("nibble", 32'(digit_nibble), 32'(exp_nib));
        check("en_n", 32'(digit_en_n), 32'(exp_en));
        check("idx", 32'(digit_idx), 32'(idx));
        check("frame_start", 32'(frame_start), 32'((n % NP) == 0));
        check("update_pending", 32'(update_pending), 32'(m_pv));
    endtask

    task automatic step(input bit l, input logic [4*N-1:0] d);
        load    = l;
        data_in = d;
        @(posedge clk);
        model_edge(l, d);
        #1;
        load    = 1'b0;
        data_in = '0;
        check_outputs();
    endtask

    initial begin
        rst_n   = 1'b0;
        load    = 1'b0;
        data_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst_hold");
        rst_n = 1'b1;

        // Free-running scan from release.
        repeat (35) step(1'b0, '0);

        // Mid-frame load, held until the next wrap.
        while (n % NP != 5) step(1'b0, '0);
        step(1'b1, 16'h1A2F);
        repeat (NP + 4) step(1'b0, '0);

        // Back-to-back loads in one frame: last write wins.
        while (n % NP != 2) step(1'b0, '0);
        step(1'b1, 16'h1111);
        step(1'b0, '0);
        step(1'b1, 16'h2222);
        repeat (2 * NP) step(1'b0, '0);

        // Load coinciding with the wrap edge bypasses staging.
        while ((n + 1) % NP != 0) step(1'b0, '0);
        step(1'b1, 16'hBEEF);
        check("wrap_load_nibble", 32'(digit_nibble), 32'hF);
        check("wrap_load_pending", 32'(update_pending), 32'h0);
        repeat (NP) step(1'b0, '0);

        // Leading zeros (blanked only when the feature is built in).
        step(1'b1, 16'h0042);
        repeat (2 * NP) step(1'b0, '0);
        step(1'b1, 16'h0000);
        repeat (2 * NP) step(1'b0, '0);

        // Async reset at idx 2 with an update pending.
        while (n % NP != 9) step(1'b0, '0);
        step(1'b1, 16'h5A5A);
        step(1'b0, '0);
        check("pending_before_rst", 32'(update_pending), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        @(posedge clk);
        #1;
        check_reset("async_rst_hold");
        rst_n = 1'b1;
        model_reset();
        repeat (2 * NP) step(1'b0, '0);

        // Randomized loads, including ones that land on wrap edges.
        repeat (400) step($urandom_range(0, 5) == 0, 16'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
